// File: rtl/scale_and_extend_pkg.sv
// Shared settings-bus map and defaults for the transmit gain stage.
// Other sdr_lib blocks import the address constants from here.
package scale_and_extend_pkg;

  localparam int BITS_IN   = 16;
  localparam int GAIN_BITS = 16;
  localparam int OUT_BITS  = BITS_IN + GAIN_BITS;

  // Settings-bus offset of the gain register.
  localparam logic [7:0] SR_GAIN_BASE = 8'd0;

  // Q2.(GAIN_BITS-2) unity.
  localparam logic [GAIN_BITS-1:0] UNITY_GAIN = GAIN_BITS'(1) << (GAIN_BITS - 2);

  function automatic logic is_reg_write(input logic stb, input logic [7:0] addr,
                                        input logic [7:0] base);
    return stb && (addr == base);
  endfunction

endpackage

// File: rtl/scale_and_extend_scale_pipe.sv
// One rail of the gain stage: input/gain register, signed full-width product,
// output register, with a 3-deep valid pipe that run clears.
module scale_pipe
  import scale_and_extend_pkg::*;
#(
  parameter int bits_in   = BITS_IN,
  parameter int gain_bits = GAIN_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          accept,
  input  logic [bits_in-1:0]            sample,
  input  logic [gain_bits-1:0]          gain,
  output logic [bits_in+gain_bits-1:0]  product,
  output logic                          stb_out
);

  localparam int PW = bits_in + gain_bits;

  logic        [bits_in-1:0]   s1_x;
  logic        [gain_bits-1:0] s1_g;
  logic signed [PW-1:0]        s1_x_ext;
  logic signed [PW-1:0]        s1_g_ext;
  logic signed [PW-1:0]        mult;
  logic        [PW-1:0]        s2_p;
  logic        [2:0]           valid;

  // Both operands are widened to the product width so the multiply is
  // exact; an in*gain product always fits in bits_in+gain_bits.
  assign s1_x_ext = {{gain_bits{s1_x[bits_in-1]}}, s1_x};
  assign s1_g_ext = {{bits_in{s1_g[gain_bits-1]}}, s1_g};
  assign mult     = s1_x_ext * s1_g_ext;

  always_ff @(posedge clk) begin
    // NOTE: state updates use <= so every stage samples the previous
    // stage's value from before this edge; = here would collapse the pipe.
    if (rst) begin
      // NOTE: the data stages are reset too (they are plain registers, not a
      // RAM), so out_i/out_q read 0 right after rst.
      s1_x    <= '0;
      s1_g    <= '0;
      s2_p    <= '0;
      product <= '0;
      valid   <= '0;
    end else begin
      valid <= run ? {valid[1:0], accept} : 3'b000;
      if (accept) begin
        s1_x <= sample;
        s1_g <= gain;
      end
      // Data only advances behind a live valid bit, so out holds between samples.
      if (run && valid[0]) s2_p    <= mult;
      if (run && valid[1]) product <= s2_p;
    end
  end

  assign stb_out = valid[2];

endmodule

// File: rtl/scale_and_extend.sv
// Transmit gain stage: signed I/Q times a settings-bus gain, widened to full
// precision, with run gating and a per-run accepted-sample counter.
module scale_and_extend
  import scale_and_extend_pkg::*;
#(
  parameter int         bits_in   = BITS_IN,
  parameter int         gain_bits = GAIN_BITS,
  parameter logic [7:0] BASE      = SR_GAIN_BASE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          set_stb,
  input  logic [7:0]                    set_addr,
  input  logic [31:0]                   set_data,
  input  logic                          run,
  input  logic [bits_in-1:0]            in_i,
  input  logic [bits_in-1:0]            in_q,
  input  logic                          stb_in,
  output logic [bits_in+gain_bits-1:0]  out_i,
  output logic [bits_in+gain_bits-1:0]  out_q,
  output logic                          stb_out,
  output logic [31:0]                   sample_count
);

  localparam logic [gain_bits-1:0] unity_gain = gain_bits'(1) << (gain_bits - 2);

  logic [gain_bits-1:0] pend_gain;
  logic [31:0]          count_q;
  logic                 run_d;
  logic                 accept;
  logic                 gain_wr;
  logic                 run_rise;
  logic                 stb_i_rail;
  logic                 stb_q_rail;
  logic                 unused_set_data;

  assign accept          = stb_in && run;
  assign gain_wr         = is_reg_write(set_stb, set_addr, BASE);
  assign run_rise        = run && !run_d;
  assign unused_set_data = ^set_data[31:gain_bits];

  // A write only touches the pending copy; the rails latch it per accept,
  // so a same-edge accept still sees the old gain.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_gain <= unity_gain;
      count_q   <= '0;
      run_d     <= 1'b0;
    end else begin
      run_d <= run;
      if (gain_wr) pend_gain <= set_data[gain_bits-1:0];
      if (run_rise)    count_q <= accept ? 32'd1 : 32'd0;
      else if (accept) count_q <= count_q + 32'd1;
    end
  end

  scale_pipe #(.bits_in(bits_in), .gain_bits(gain_bits)) u_pipe_i (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .accept  (accept),
    .sample  (in_i),
    .gain    (pend_gain),
    .product (out_i),
    .stb_out (stb_i_rail)
  );

  scale_pipe #(.bits_in(bits_in), .gain_bits(gain_bits)) u_pipe_q (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .accept  (accept),
    .sample  (in_q),
    .gain    (pend_gain),
    .product (out_q),
    .stb_out (stb_q_rail)
  );

  assign stb_out      = stb_i_rail;
  assign sample_count = count_q;

  // Both rails see identical accept/run, so their valid pipes never diverge.
  a_rails_lockstep : assert property (@(posedge clk) stb_i_rail == stb_q_rail);

endmodule

// File: doc/scale_and_extend.md
# scale_and_extend

Transmit-path gain stage: accepts narrow signed I/Q samples with a strobe, multiplies both by a programmable signed gain, and delivers full-precision widened I/Q with a matching strobe after a fixed pipeline delay. It sits ahead of the DUC/interpolator, where narrow host samples are scaled up. It is the counterpart of the receive-side clip-and-round narrowing stage. Gain is written over the settings bus. The block also counts accepted samples per run.

## Interface
- bits_in, 16, input sample width per rail (signed)
- gain_bits, 16, gain word width (signed, Q2.(gain_bits-2))
- BASE, 0, settings-bus address of the gain register
- clk  in  1  system clock; everything is synchronous to it
- rst  in  1  reset, synchronous, active-high
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data; gain is taken from set_data[gain_bits-1:0]
- run  in  1  enable; when low the pipeline is flushed
- in_i, in_q  in  bits_in each  signed input samples
- stb_in  in  1  input sample valid, single-cycle
- out_i, out_q  out  bits_in+gain_bits each  signed scaled samples, registered
- stb_out  out  1  output valid
- sample_count  out  32  samples accepted since run last rose

## Operation
- Gain register: written when set_stb && set_addr==BASE. The write lands in the pending gain register only.
- Reset value of pending gain: 1<<(gain_bits-2), which is unity, 16'h4000 for gain_bits=16.
- Pending gain is copied into the stage-1 gain when a sample is accepted, so a gain change never splits a sample. The I and Q rails of a sample always share the same gain.
- Accept condition: stb_in && run.
- On accept:
  - stage 1 registers in_i, in_q and the gain;
  - stage 2 forms full signed products of width bits_in+gain_bits; the product cannot overflow;
  - stage 3 registers the products into out_i and out_q.
- Valid tracking: a 3-bit valid shift register follows the data. stb_out is its last bit.
- run low: all valid bits clear on the next edge. Data registers hold their values.
- run falling with a sample in flight: that sample is dropped and no stb_out is issued for it.
- sample_count:
  - cleared to 0 on the cycle after run rises;
  - increments on each accept;
  - wraps 0xFFFFFFFF to 0;
  - holds its value while run is low.
- stb_in while run is low: ignored; no count, no output.
- Settings write and accept in the same cycle: the sample uses the old pending gain. The new gain applies from the next accept.

## Timing
- Latency: stb_in at edge N produces stb_out at edge N+3. Values are bit-exact: out = in * gain.
- Throughput: one sample per clock. Back-to-back strobes are supported.
- Gain write visibility: a write at edge W affects the first sample accepted at an edge after W.
- rst: out_i, out_q, stb_out, sample_count and the valid bits all go to 0, and pending gain returns to unity, on the same edge. rst mid-stream drops every in-flight sample.
- No backpressure. The downstream consumer must take the sample on the stb_out cycle.

## Structure
- The settings offset BASE and the unity-gain constant go in the shared settings-address include used by the other sdr_lib blocks.
- One sub-module: scale_pipe, a 3-stage registered signed multiplier with a valid pipe. It is instantiated once per rail, and the I instance supplies stb_out.
- The top level holds the settings register, the gain hand-off, run gating and sample_count.

## Test plan
- After rst, send in_i=0x7FFF and in_q=0x8000 with one stb_in and run=1 -> three cycles later stb_out=1, out_i=0x1FFFC000, out_q=0xE0000000.
- Write gain=0x2000 at the same edge as an accept of in_i=0x0100 (first sample), then accept 0x0100 again -> first output 0x00400000, second output 0x00200000.
- Apply stb_in every cycle for 100 cycles -> stb_out high for 100 consecutive cycles starting at cycle 3, and sample_count=100.
- Drop run with two samples in flight -> no stb_out for those samples; raise run again -> sample_count reads 0, then counts from 1.
- Preload sample_count near wrap (force to 0xFFFFFFFE) and accept 3 samples -> counts 0xFFFFFFFF, 0, 1.
- Assert rst mid-stream with gain=0x1000 -> all outputs 0 next cycle, and the next sample is scaled by unity.
